// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: 2-FF sync, optional glitch filter (QUAD_DEC_FILTER_EN), x4 decode into a wrapping counter.
// Without QUAD_DEC_FILTER_EN every synchronized change is accepted on the next edge and FILTER is ignored.
module quad_decoder #(
    parameter int WIDTH  = 4,
    parameter int FILTER = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enc_a_i,
    input  logic             enc_b_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             mode_o,
    output logic             step_o,
    output logic             wrap_o,
    output logic             err_o
);

    // state    | meaning
    // ST_PRIME | next accepted update only loads f (encoder may rest anywhere)
    // ST_RUN   | accepted updates are decoded into steps / errors
    typedef enum logic {ST_PRIME, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       f_q, f_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             accept;
    logic             illegal;
    logic             up;

`ifdef QUAD_DEC_FILTER_EN
    localparam logic [3:0] FILT_TC = 4'(FILTER - 1);
    logic [1:0] s_prev_q;
    logic [3:0] stab_q, stab_d;
    logic [3:0] stab_eff;

    // A change of the candidate value restarts the stability count.
    always_comb begin
        stab_eff = (sync2_q != s_prev_q) ? 4'd0 : stab_q;
        accept   = (sync2_q != f_q) && (stab_eff == FILT_TC);
        stab_d   = (sync2_q == f_q || accept) ? 4'd0 : stab_eff + 4'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_prev_q <= 2'b00;
            stab_q   <= 4'd0;
        end else begin
            s_prev_q <= sync2_q;
            stab_q   <= stab_d;
        end
    end
`else
    always_comb begin
        accept = (sync2_q != f_q);
    end
`endif

    always_comb begin
        illegal = ((f_q ^ sync2_q) == 2'b11);
        case ({f_q, sync2_q})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: up = 1'b1;
            default:                                up = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        count_d = count_q;
        mode_d  = mode_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (accept) begin
            f_d = sync2_q;
            if (state_q == ST_PRIME) begin
                state_d = ST_RUN;
            end else if (illegal) begin
                err_d = 1'b1;
            end else begin
                mode_d = up;
                step_d = 1'b1;
                if (up) begin
                    count_d = count_q + 1'b1;
                    wrap_d  = (count_q == '1);
                end else begin
                    count_d = count_q - 1'b1;
                    wrap_d  = (count_q == '0);
                end
            end
        end
        // An error accepted in the clear cycle survives the clear.
        if (clr_i) begin
            count_d = '0;
            step_d  = 1'b0;
            wrap_d  = 1'b0;
            err_d   = accept && (state_q == ST_RUN) && illegal;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_PRIME;
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            f_q     <= 2'b00;
            count_q <= '0;
            mode_q  <= 1'b1;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= {enc_a_i, enc_b_i};
            sync2_q <= sync1_q;
            f_q     <= f_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign mode_o  = mode_q;
    assign step_o  = step_q;
    assign wrap_o  = wrap_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=4, FILTER=2); expectations adapt to whether QUAD_DEC_FILTER_EN is defined.
module tb_quad_decoder;

    localparam int WIDTH  = 4;
    localparam int FILTER = 2;
`ifdef QUAD_DEC_FILTER_EN
    localparam int LAT = FILTER + 1;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enc_a = 1'b0;
    logic             enc_b = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] count;
    logic             mode, step, wrap, err;

    int checks = 0;
    int failures = 0;

    quad_decoder #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enc_a_i(enc_a), .enc_b_i(enc_b), .clr_i(clr),
        .count_o(count), .mode_o(mode), .step_o(step), .wrap_o(wrap), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            enc_a = i[0];
            enc_b = i[1];
            tick();
            checks++;
            if (count !== 4'd0 || mode !== 1'b1 || step !== 1'b0 || wrap !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got cnt=%0d mode=%b step=%b wrap=%b err=%b want 0 1 0 0 0",
                         i, count, mode, step, wrap, err);
            end
        end
        enc_a = 1'b1;
        enc_b = 1'b1;
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (count !== 4'd0 || step !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL reset_prime cyc=%0d got cnt=%0d step=%b err=%b want 0 0 0", i, count, step, err);
            end
        end
    endtask

    // From primed 11: two up steps to 00, then a lone clear.
    task automatic test_clear_idle();
        logic [1:0] ab [2];
        ab[0] = 2'b01;
        ab[1] = 2'b00;
        for (int k = 0; k < 2; k++) begin
            {enc_a, enc_b} = ab[k];
            for (int i = 0; i <= LAT + 1; i++) begin
                tick();
                if (i == LAT) begin
                    checks++;
                    if (step !== 1'b1 || count !== 4'(k + 1) || mode !== 1'b1) begin
                        failures++;
                        $display("FAIL prime_walk k=%0d got step=%b cnt=%0d mode=%b want 1 %0d 1", k, step, count, mode, k + 1);
                    end
                end
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (count !== 4'd0 || err !== 1'b0 || step !== 1'b0 || mode !== 1'b1) begin
            failures++;
            $display("FAIL clr_idle got cnt=%0d err=%b step=%b mode=%b want 0 0 0 1", count, err, step, mode);
        end
    endtask

    task automatic test_up_down();
        logic [1:0] ab [8];
        logic [3:0] exp_cnt [8];
        logic [3:0] prev;
        ab = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        prev = 4'd0;
        for (int k = 0; k < 8; k++) begin
            {enc_a, enc_b} = ab[k];
            for (int i = 0; i <= LAT + 1; i++) begin
                tick();
                checks++;
                if (step !== (i == LAT) || wrap !== 1'b0) begin
                    failures++;
                    $display("FAIL updown_pulse k=%0d i=%0d got step=%b wrap=%b want %b 0", k, i, step, wrap, (i == LAT));
                end
                if (i == LAT - 1) begin
                    checks++;
                    if (count !== prev) begin
                        failures++;
                        $display("FAIL updown_early k=%0d got cnt=%0d want %0d", k, count, prev);
                    end
                end
                if (i == LAT) begin
                    checks++;
                    if (count !== exp_cnt[k] || mode !== (k < 4)) begin
                        failures++;
                        $display("FAIL updown_step k=%0d got cnt=%0d mode=%b want %0d %b", k, count, mode, exp_cnt[k], (k < 4));
                    end
                end
            end
            prev = exp_cnt[k];
        end
    endtask

    // 00->01 down wraps 0->15, 01->00 up wraps 15->0, twice.
    task automatic test_wrap();
        for (int k = 0; k < 4; k++) begin
            {enc_a, enc_b} = (k % 2 == 0) ? 2'b01 : 2'b00;
            for (int i = 0; i <= LAT + 1; i++) begin
                tick();
                checks++;
                if (wrap !== (i == LAT) || step !== (i == LAT)) begin
                    failures++;
                    $display("FAIL wrap_pulse k=%0d i=%0d got wrap=%b step=%b want %b", k, i, wrap, step, (i == LAT));
                end
                if (i == LAT) begin
                    checks++;
                    if (count !== ((k % 2 == 0) ? 4'd15 : 4'd0) || mode !== (k % 2 == 1)) begin
                        failures++;
                        $display("FAIL wrap_cnt k=%0d got cnt=%0d mode=%b want %0d %b",
                                 k, count, mode, (k % 2 == 0) ? 15 : 0, (k % 2 == 1));
                    end
                end
            end
        end
    endtask

    task automatic test_illegal_clear();
        {enc_a, enc_b} = 2'b10;
        repeat (LAT + 2) tick();
        checks++;
        if (count !== 4'd1) begin
            failures++;
            $display("FAIL illegal_pre got cnt=%0d want 1", count);
        end
        {enc_a, enc_b} = 2'b01;
        for (int i = 0; i <= LAT + 1; i++) begin
            tick();
            checks++;
            if (step !== 1'b0 || count !== 4'd1 || mode !== 1'b1 || err !== (i >= LAT)) begin
                failures++;
                $display("FAIL illegal i=%0d got step=%b cnt=%0d mode=%b err=%b want 0 1 1 %b",
                         i, step, count, mode, err, (i >= LAT));
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (count !== 4'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clr got cnt=%0d err=%b want 0 0", count, err);
        end
        {enc_a, enc_b} = 2'b11;
        repeat (LAT + 2) tick();
        checks++;
        if (count !== 4'd15 || mode !== 1'b0) begin
            failures++;
            $display("FAIL clr_setup got cnt=%0d mode=%b want 15 0", count, mode);
        end
        {enc_a, enc_b} = 2'b01;
        for (int i = 0; i <= LAT + 1; i++) begin
            clr = (i == LAT);
            tick();
            checks++;
            if (step !== 1'b0 || wrap !== 1'b0) begin
                failures++;
                $display("FAIL clr_step_pulse i=%0d got step=%b wrap=%b want 0 0", i, step, wrap);
            end
            if (i == LAT) begin
                checks++;
                if (count !== 4'd0 || mode !== 1'b1) begin
                    failures++;
                    $display("FAIL clr_step got cnt=%0d mode=%b want 0 1", count, mode);
                end
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_filter();
        logic [3:0] want_cnt;
        logic       want_step;
        {enc_a, enc_b} = 2'b00;
        repeat (LAT + 2) tick();
        checks++;
        if (count !== 4'd1 || mode !== 1'b1) begin
            failures++;
            $display("FAIL filter_pre got cnt=%0d mode=%b want 1 1", count, mode);
        end
        enc_a = 1'b1;
        tick();
        enc_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
`ifdef QUAD_DEC_FILTER_EN
            want_cnt  = 4'd1;
            want_step = 1'b0;
`else
            want_cnt  = (i == 2) ? 4'd2 : 4'd1;
            want_step = (i == 2 || i == 3);
`endif
            checks++;
            if (count !== want_cnt || step !== want_step || err !== 1'b0) begin
                failures++;
                $display("FAIL glitch i=%0d got cnt=%0d step=%b err=%b want %0d %b 0",
                         i, count, step, err, want_cnt, want_step);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] ab [6];
        ab = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
        for (int k = 0; k < 6; k++) begin
            {enc_a, enc_b} = ab[k];
            repeat (LAT + 2) tick();
        end
        {enc_a, enc_b} = 2'b01;
        tick();
        tick();
        checks++;
        if (count !== 4'd7 || step !== 1'b0) begin
            failures++;
            $display("FAIL mid_pre got cnt=%0d step=%b want 7 0", count, step);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || mode !== 1'b1 || step !== 1'b0 || wrap !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL mid_async got cnt=%0d mode=%b step=%b wrap=%b err=%b want 0 1 0 0 0",
                     count, mode, step, wrap, err);
        end
        tick();
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (count !== 4'd0 || step !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL mid_prime i=%0d got cnt=%0d step=%b err=%b want 0 0 0", i, count, step, err);
            end
        end
        {enc_a, enc_b} = 2'b00;
        for (int i = 0; i <= LAT + 1; i++) begin
            tick();
            if (i == LAT) begin
                checks++;
                if (count !== 4'd1 || step !== 1'b1 || mode !== 1'b1) begin
                    failures++;
                    $display("FAIL mid_after got cnt=%0d step=%b mode=%b want 1 1 1", count, step, mode);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_idle();
        test_up_down();
        test_wrap();
        test_illegal_clear();
        test_filter();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature (A/B) position decoder: synchronizes and filters two encoder phase inputs and converts each legal phase transition into a +1/−1 step. The steps drive a WIDTH-bit wrapping position counter. The outputs use the same count/mode semantics as the team's up/down counter. `quad_decoder` sits on the sensor-input side: the encoder phases enter here, and the `count` and `mode` outputs feed downstream logic.

## Interface
- `WIDTH`, default 4: position counter width in bits.
- `FILTER`, default 2: consecutive stable cycles required before a synchronized phase change is accepted. Legal values: 1 to 15.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low. Asserted when 0.
- `enc_a` input, 1 bit: encoder phase A, asynchronous to `clk`.
- `enc_b` input, 1 bit: encoder phase B, asynchronous to `clk`.
- `clr` input, 1 bit: synchronous clear of `count` and `err`.
- `count` output, WIDTH bits: current position.
- `mode` output, 1 bit: direction of the last accepted step. 1 = up, 0 = down.
- `step` output, 1 bit: one-cycle pulse on each accepted legal transition.
- `wrap` output, 1 bit: one-cycle pulse when `count` wraps (max→0 or 0→max).
- `err` output, 1 bit: sticky flag for an illegal transition (both phases changed).

## Operation
- **Synchronizer:** each phase passes through a 2-FF synchronizer, giving `s = {a_s, b_s}`.
- **Filter:** keeps the accepted phase pair `f` and a stability counter.
  - If `s == f`, the stability counter clears to 0.
  - If `s != f`, the counter increments.
  - When `s != f` and the counter equals FILTER−1, `f` loads `s` on that edge. This is an accepted update.
  - If `s` changes value before acceptance, the counter restarts from 0.
- **Decode:** evaluated on each accepted update by comparing the old `f` with the new `s` (`{A,B}`).
  - Up sequence: 00→10→11→01→00. Sets `mode`=1 and `count`+1.
  - Down sequence: 00→01→11→10→00. Sets `mode`=0 and `count`−1.
  - Both bits changed is illegal: `err` is set to 1, and `count`, `mode`, `step` and `wrap` are unchanged.
  - Every accepted legal transition counts (x4 decoding).
- **Arithmetic:** modulo 2^WIDTH.
  - Up from 2^WIDTH−1 → 0 pulses `wrap`.
  - Down from 0 → 2^WIDTH−1 pulses `wrap`.
- **Priming:** the first accepted update after reset only loads `f`. There is no decode, no `err` and no `step`. This prevents a spurious error when the encoder rests at a non-00 phase during reset.
- **Clear (`clr`):**
  - `clr`=1 forces `count` to 0 and suppresses `step` and `wrap` that cycle.
  - `mode` and `f` still update normally.
  - `err` is cleared unless an illegal transition is accepted in the same cycle, in which case `err`=1. An error is never lost.
- **Reset:** asynchronous. While `reset`=0:
  - `count`=0, `mode`=1, `step`=0, `wrap`=0, `err`=0.
  - Synchronizers=00, `f`=00, stability counter=0, priming pending.
  - Deassertion mid-transition discards any partially filtered change.

## Timing
- All outputs are registered.
- **Latency:** an input change sampled at edge N reaches `s` at edge N+1. It is accepted and updates `count`, `mode`, `step` and `wrap` at edge N+FILTER+1. With FILTER=2, this is 3 edges after the sampling edge.
- **Minimum legal step spacing:** FILTER+1 cycles. Faster phase changes are filtered or merged. If merged into a two-bit change, `err` is set.
- **Pulse width:** `step` and `wrap` are high for exactly one cycle per accepted transition.
- **Pulse rate:** back-to-back accepted transitions can produce pulses at most every FILTER cycles.
- **Clear timing:** `clr` takes effect on the same edge it is sampled.

## Configuration
- **`QUAD_DEC_FILTER_EN`:**
  - **Defined:** the glitch filter is present as described, and the FILTER parameter is honoured.
  - **Undefined:** the filter is removed. `f` loads `s` every cycle, and any `s != f` is an accepted update. Latency is fixed at 2 edges after the sampling edge, and FILTER is ignored.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=4 and FILTER=2 with the macro defined, except scenario 5.

1. **Reset values:** hold `reset`=0 with inputs toggling → `count`=0, `mode`=1, `step`=0, `wrap`=0, `err`=0 throughout. After release with A/B=11, a priming update only: `count` stays 0, `err` stays 0.
2. **Up/down steps:** from 00, drive 10, 11, 01, 00, each held 4 cycles → `count` steps 0→1→2→3→4, `mode`=1, four single-cycle `step` pulses, each 3 edges after its input change. Then reverse 01, 11, 10, 00 → `count` returns to 0, `mode`=0.
3. **Wrap:** reach `count`=15 and take one up step → `count`=0 with `wrap` for 1 cycle. Then one down step → `count`=15 with `wrap` for 1 cycle.
4. **Illegal transition and clear:**
   - Jump 00→11 → `err`=1, `count` unchanged, no `step`.
   - Assert `clr` for 1 cycle → `count`=0 and `err`=0.
   - `clr` coincident with an accepted legal step → `count`=0 and no `step`.
5. **Filter behaviour:**
   - A 1-cycle glitch on A → no `count` change.
   - Build with `QUAD_DEC_FILTER_EN` undefined: the same 1-cycle glitch produces +1 then −1 steps.
6. **Reset mid-operation:** assert `reset` at `count`=7 while a change is half-filtered → all outputs return to reset values immediately. The next accepted update after release is a priming update.
